// File: rtl/sram_controller.sv
// Memory-stage front end: moves a 32-bit load/store over a 16-bit asynchronous
// SRAM as two half-word phases (low half first), stalling the pipeline via ready.
module sram_controller #(
    parameter int WAIT_CYCLES = 1,
    parameter int SRAM_ADDR_W = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_read_en,
    input  logic                   mem_write_en,
    input  logic [31:0]            alu_res,
    input  logic [31:0]            val_rm,
    output logic [31:0]            value,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [15:0]            sram_dq_out,
    input  logic [15:0]            sram_dq_in,
    output logic                   sram_dq_oe,
    output logic                   sram_we_n
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOW  = 2'd1;
    localparam logic [1:0] S_HIGH = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int              CNT_W    = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

    logic [1:0]             state_reg, state_next;
    logic [CNT_W-1:0]       count_reg, count_next;
    logic                   op_write_reg, op_write_next;
    logic [SRAM_ADDR_W-1:0] addr_reg, addr_next;
    logic [15:0]            dq_out_reg, dq_out_next;
    logic                   oe_reg, oe_next;
    logic                   we_n_reg, we_n_next;
    logic                   request;
    logic                   phase_last;

    assign request    = mem_read_en | mem_write_en;
    assign phase_last = (count_reg == CNT_LAST);
    assign ready      = ((state_reg == S_IDLE) && !request) || (state_reg == S_DONE);

    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        op_write_next = op_write_reg;
        case (state_reg)
            S_IDLE: begin
                if (request) begin
                    state_next    = S_LOW;
                    count_next    = '0;
                    op_write_next = mem_write_en;
                end
            end
            S_LOW: begin
                if (phase_last) begin
                    state_next = S_HIGH;
                    count_next = '0;
                end else begin
                    count_next = count_reg + 1'b1;
                end
            end
            S_HIGH: begin
                if (phase_last) begin
                    state_next = S_DONE;
                    count_next = '0;
                end else begin
                    count_next = count_reg + 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
                count_next = '0;
            end
        endcase
    end

    // SRAM pins are registered from the upcoming state so we_n is glitch-free
    // while still lining up exactly with the phase counter.
    always_comb begin
        addr_next   = '0;
        dq_out_next = '0;
        oe_next     = 1'b0;
        we_n_next   = 1'b1;
        if ((state_next == S_LOW) || (state_next == S_HIGH)) begin
            addr_next = {alu_res[SRAM_ADDR_W:2], (state_next == S_HIGH)};
            if (op_write_next) begin
                dq_out_next = (state_next == S_HIGH) ? val_rm[31:16] : val_rm[15:0];
                oe_next     = 1'b1;
                we_n_next   = (count_next == CNT_LAST);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            count_reg    <= '0;
            op_write_reg <= 1'b0;
            addr_reg     <= '0;
            dq_out_reg   <= '0;
            oe_reg       <= 1'b0;
            we_n_reg     <= 1'b1;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            op_write_reg <= op_write_next;
            addr_reg     <= addr_next;
            dq_out_reg   <= dq_out_next;
            oe_reg       <= oe_next;
            we_n_reg     <= we_n_next;
        end
    end

    assign sram_addr   = addr_reg;
    assign sram_dq_out = dq_out_reg;
    assign sram_dq_oe  = oe_reg;
    assign sram_we_n   = we_n_reg;

    // Each half of the load word is sampled at the end of its own phase.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_capture
            localparam logic [1:0] CAPTURE_STATE = (gi == 0) ? S_LOW : S_HIGH;
            logic [15:0] half_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    half_reg <= '0;
                end else if ((state_reg == CAPTURE_STATE) && phase_last && !op_write_reg) begin
                    half_reg <= sram_dq_in;
                end
            end

            assign value[gi*16 +: 16] = half_reg;
        end
    endgenerate

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
Memory-stage front end that turns the pipeline's single-cycle data-memory request (mem_read_en / mem_write_en, address alu_res, store data val_rm) into a multi-cycle transaction on an external 16-bit asynchronous SRAM. Each 32-bit word is moved as two 16-bit halves, low half first. The block stalls the pipeline with ready until the transaction completes, then returns load data on value.

Parameters:
WAIT_CYCLES, 1, extra cycles each half-phase is held; phase length = WAIT_CYCLES+1; legal range >= 1
SRAM_ADDR_W, 18, SRAM half-word address width

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
mem_read_en  input  1  load request; held stable by pipeline while ready=0
mem_write_en  input  1  store request; held stable by pipeline while ready=0
alu_res  input  32  byte address; bits [18:2] select the word
val_rm  input  32  store data
value  output  32  registered load data
ready  output  1  1 = no stall; 0 = pipeline must freeze
sram_addr  output  SRAM_ADDR_W  half-word address = {alu_res[18:2], half}, half 0 = low
sram_dq_out  output  16  write data to SRAM
sram_dq_in  input  16  read data from SRAM
sram_dq_oe  output  1  1 = controller drives SRAM data bus
sram_we_n  output  1  SRAM write enable, active-low

Behaviour:
- States: IDLE, LOW, HIGH, DONE. Phase counter counts 0..WAIT_CYCLES inside LOW and HIGH.
- Reset (synchronous, any state): state=IDLE, counter=0, value=0, sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0.
- ready is combinational:
  - ready=1 in IDLE with no request, and in DONE.
  - ready=0 in IDLE with a request, and in LOW and HIGH.
- IDLE:
  - If mem_write_en or mem_read_en is high, go to LOW next edge and latch the operation type. Write has priority if both are high; value is untouched.
  - Otherwise stay in IDLE.
- LOW phase:
  - sram_addr={alu_res[18:2],0}.
  - On a write: sram_dq_out=val_rm[15:0], sram_dq_oe=1, sram_we_n=0 for counter < WAIT_CYCLES, and sram_we_n=1 on the last phase cycle (data/address hold).
  - On a read: sram_dq_oe=0, sram_we_n=1, and value[15:0] is captured from sram_dq_in at the edge ending the last phase cycle.
  - Go to HIGH after WAIT_CYCLES+1 cycles.
- HIGH phase: identical to LOW but with sram_addr={alu_res[18:2],1}, val_rm[31:16], and capture into value[31:16]. Go to DONE after WAIT_CYCLES+1 cycles.
- DONE: one cycle. ready=1, value holds the full word, SRAM idle (we_n=1, oe=0). Next state is IDLE unconditionally. The pipeline advances on this edge, so a request seen afterwards in IDLE is a new instruction.
- Stall length:
  - ready=0 for 1 + 2*(WAIT_CYCLES+1) cycles per access (5 cycles with WAIT_CYCLES=1), followed by 1 DONE cycle.
  - Back-to-back accesses add 1 IDLE cycle between transactions.
- value changes only on read captures and on reset. Writes never alter value.
- Address bits [31:19] and [1:0] are ignored; no alignment checking.
- Request deasserted mid-transaction (protocol violation): the transaction completes anyway using the latched operation type.
- Reset mid-transaction: abort immediately; the SRAM may hold a partial word.

Test Plan:
- Write then read: write alu_res=0x00000008, val_rm=0xDEADBEEF -> SRAM half-address 4 receives 0xBEEF and address 5 receives 0xDEAD, with we_n low 1 cycle per phase. Then read 0x00000008 -> value=0xDEADBEEF when ready rises.
- Stall count (WAIT_CYCLES=1): hold mem_read_en -> ready low for exactly 5 cycles, high in DONE; value unchanged until the LOW/HIGH capture edges.
- Simultaneous enables: both high, val_rm=0x12345678, prior value=0xCAFEF00D -> write performed, value stays 0xCAFEF00D.
- Reset mid-op: assert rst during the HIGH phase of a write -> next cycle state IDLE, we_n=1, oe=0, value=0, ready=1 with requests low.
- Back-to-back loads: 0x10 then 0x14, preloaded 0x11112222 / 0x33334444 -> each value correct, second transaction starts one cycle after DONE.
- WAIT_CYCLES=3: one write -> each phase lasts 4 cycles with we_n low for 3; ready low for 9 cycles.
